// File: rtl/apb_slave_mem.sv
// Byte-wide APB slave: register memory, lock control register, programmable
// wait states on pready, pslverr on bad address / locked write, saturating error counter.
module apb_slave_mem #(
   parameter int         DEPTH       = 64,
   parameter int         WAIT_CYCLES = 2,
   parameter logic [7:0] CTRL_ADDR   = 8'hFF
) (
   input  logic       pclk,
   input  logic       presetn,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [8:0] paddr,
   input  logic [7:0] pwdata,
   output logic       pready,
   output logic       pslverr,
   output logic [7:0] prdata,
   output logic       lock,
   output logic [7:0] err_count
);

   localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [8:0] DEPTH_W = 9'(DEPTH);
   localparam logic [3:0] WAIT_W  = 4'(WAIT_CYCLES);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t     state_reg, state_next;
   logic [3:0] wait_cnt_reg, wait_cnt_next;
   logic [7:0] addr_reg;
   logic       write_reg;
   logic [7:0] wdata_reg;
   logic       ctrl_reg;
   logic [7:0] err_count_reg;
   logic [7:0] mem [DEPTH];

   logic       capture;
   logic       is_ctrl;
   logic       in_range;
   logic       error;
   logic       unused_addr_bit;

   // Bit 8 is the master's slave decode and carries no information here.
   assign unused_addr_bit = paddr[8];

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      capture       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (psel && !penable) begin
               capture       = 1'b1;
               wait_cnt_next = WAIT_W;
               state_next    = ACCESS;
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_next = IDLE;
            end else if (wait_cnt_reg != 4'd0) begin
               wait_cnt_next = wait_cnt_reg - 4'd1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_reg    <= IDLE;
         wait_cnt_reg <= 4'd0;
         addr_reg     <= 8'd0;
         write_reg    <= 1'b0;
         wdata_reg    <= 8'd0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         if (capture) begin
            addr_reg  <= paddr[7:0];
            write_reg <= pwrite;
            wdata_reg <= pwdata;
         end
      end
   end

   // Decode works only on the captured address/direction, never the live bus.
   assign is_ctrl  = (addr_reg == CTRL_ADDR);
   assign in_range = ({1'b0, addr_reg} < DEPTH_W);
   assign error    = !is_ctrl && (!in_range || (write_reg && ctrl_reg));

   assign pready  = (state_reg == ACCESS) && (wait_cnt_reg == 4'd0) && psel && penable;
   assign pslverr = pready && error;

   always_comb begin
      prdata = 8'd0;
      if (pready && !write_reg && !error) begin
         if (is_ctrl) prdata = {7'd0, ctrl_reg};
         else         prdata = mem[addr_reg[AW-1:0]];
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         ctrl_reg      <= 1'b0;
         err_count_reg <= 8'd0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'd0;
      end else if (pready) begin
         if (error) begin
            if (err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
         end else if (write_reg) begin
            if (is_ctrl) ctrl_reg <= wdata_reg[0];
            else         mem[addr_reg[AW-1:0]] <= wdata_reg;
         end
      end
   end

   assign lock      = ctrl_reg;
   assign err_count = err_count_reg;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Two slaves on one APB bus (WAIT_CYCLES=2 on psel1, 0 on psel2); a transaction-level
// model pushes expected responses, a negedge monitor pops them when pready is seen.
`timescale 1ns/1ps
module tb_apb_slave_mem;

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      logic       wr;
      logic [7:0] addr;
   } exp_t;

   logic       pclk = 1'b0;
   logic       presetn = 1'b0;
   logic       psel1 = 1'b0, psel2 = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [8:0] paddr = 9'd0;
   logic [7:0] pwdata = 8'd0;
   logic       pready1, pslverr1, lock1, pready2, pslverr2, lock2;
   logic [7:0] prdata1, err_count1, prdata2, err_count2;

   int tests = 0;
   int fails = 0;

   exp_t q1[$];
   exp_t q2[$];

   logic [7:0] mmem [2][64];
   bit         mlock [2];
   int         merr [2];

   always #5 pclk = ~pclk;

   apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(2), .CTRL_ADDR(8'hFF)) dut1 (
      .pclk(pclk), .presetn(presetn), .psel(psel1), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pready(pready1), .pslverr(pslverr1),
      .prdata(prdata1), .lock(lock1), .err_count(err_count1));

   apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(0), .CTRL_ADDR(8'hFF)) dut2 (
      .pclk(pclk), .presetn(presetn), .psel(psel2), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pready(pready2), .pslverr(pslverr2),
      .prdata(prdata2), .lock(lock2), .err_count(err_count2));

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 64; a++) mmem[s][a] = 8'd0;
         mlock[s] = 1'b0;
         merr[s]  = 0;
      end
   endtask

   // Monitor: scoreboard pop on every pready; outside pready the response must be quiet.
   always @(negedge pclk) begin
      exp_t e;
      if (pready1) begin
         if (q1.size() == 0) begin
            check("s1_unexpected_pready", 1, 0);
         end else begin
            e = q1.pop_front();
            $display("[TB] s1 %s a=%02h prdata=%02h pslverr=%0b", e.wr ? "WR" : "RD", e.addr, prdata1, pslverr1);
            check("s1_prdata", prdata1, e.rdata);
            check("s1_pslverr", pslverr1, e.err);
         end
      end else if (presetn) begin
         check("s1_idle_quiet", {pslverr1, prdata1}, 0);
      end
      if (pready2) begin
         if (q2.size() == 0) begin
            check("s2_unexpected_pready", 1, 0);
         end else begin
            e = q2.pop_front();
            $display("[TB] s2 %s a=%02h prdata=%02h pslverr=%0b", e.wr ? "WR" : "RD", e.addr, prdata2, pslverr2);
            check("s2_prdata", prdata2, e.rdata);
            check("s2_pslverr", pslverr2, e.err);
         end
      end else if (presetn) begin
         check("s2_idle_quiet", {pslverr2, prdata2}, 0);
      end
   end

   // One complete transfer starting at posedge+1; leaves the bus at the next posedge+1.
   task automatic xfer(input int s, input bit w, input logic [7:0] a, input logic [7:0] d);
      int   i, cyc;
      bit   done;
      exp_t e;
      i = s - 1;
      e.wr    = w;
      e.addr  = a;
      e.err   = (a != 8'hFF) && ((a >= 8'd64) || (w && mlock[i]));
      e.rdata = 8'd0;
      if (!w && !e.err) e.rdata = (a == 8'hFF) ? {7'd0, mlock[i]} : mmem[i][a[5:0]];
      if (e.err) merr[i] = (merr[i] < 255) ? merr[i] + 1 : 255;
      else if (w && a == 8'hFF) mlock[i] = d[0];
      else if (w) mmem[i][a[5:0]] = d;
      if (s == 1) q1.push_back(e);
      else        q2.push_back(e);

      psel1 = (s == 1); psel2 = (s == 2);
      penable = 1'b0; pwrite = w; paddr = {i[0], a}; pwdata = d;
      @(posedge pclk); #1;
      penable = 1'b1;
      pwdata  = ~d;   // captured data must be used, not the live bus
      cyc = 0; done = 0;
      while (!done && cyc < 40) begin
         cyc++;
         @(negedge pclk);
         if ((s == 1 && pready1) || (s == 2 && pready2)) done = 1;
         @(posedge pclk); #1;
      end
      check(s == 1 ? "s1_access_cycles" : "s2_access_cycles", done ? cyc : -1, s == 1 ? 3 : 1);
      psel1 = 1'b0; psel2 = 1'b0; penable = 1'b0;
   endtask

   task automatic idle(input int n);
      psel1 = 1'b0; psel2 = 1'b0; penable = 1'b0;
      repeat (n) begin @(posedge pclk); #1; end
   endtask

   task automatic check_status(input int s);
      if (s == 1) begin
         check("s1_err_count", err_count1, merr[0]);
         check("s1_lock", lock1, mlock[0]);
      end else begin
         check("s2_err_count", err_count2, merr[1]);
         check("s2_lock", lock2, mlock[1]);
      end
   endtask

   initial begin
      int         r;
      logic [7:0] a;
      model_reset();
      #1;
      check("rst_pready", {pready1, pready2}, 0);
      check("rst_prdata", {prdata1, prdata2}, 0);
      check("rst_pslverr", {pslverr1, pslverr2}, 0);
      check_status(1);
      check_status(2);
      repeat (2) @(posedge pclk);
      #1 presetn = 1'b1;
      @(posedge pclk); #1;

      // basic write/read with wait states
      xfer(1, 1, 8'h05, 8'hA5);
      xfer(1, 0, 8'h05, 8'h00);

      // zero-wait back-to-back
      for (int k = 0; k < 4; k++) xfer(2, 1, 8'(k), 8'(8'h11 * (k + 1)));
      for (int k = 0; k < 4; k++) xfer(2, 0, 8'(k), 8'h00);
      idle(1);

      // out-of-range errors
      xfer(1, 0, 8'h40, 8'h00);
      xfer(1, 1, 8'h80, 8'h5C);
      idle(1);
      check_status(1);
      xfer(1, 0, 8'h05, 8'h00);

      // lock behaviour
      xfer(1, 1, 8'hFF, 8'h01);
      idle(1);
      check_status(1);
      xfer(1, 1, 8'h05, 8'h77);
      xfer(1, 0, 8'h05, 8'h00);
      xfer(1, 0, 8'hFF, 8'h00);
      xfer(1, 1, 8'hFF, 8'h00);
      xfer(1, 1, 8'h05, 8'h77);
      xfer(1, 0, 8'h05, 8'h00);
      idle(1);
      check_status(1);

      // asynchronous reset in the middle of a write to 0x06
      psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h006; pwdata = 8'h5A;
      @(posedge pclk); #1 penable = 1'b1;
      @(posedge pclk); #1;
      presetn = 1'b0;
      #1;
      check("async_rst_pready", pready1, 0);
      check("async_rst_outs", {pslverr1, prdata1}, 0);
      check("async_rst_err_count", err_count1, 0);
      check("async_rst_lock", lock1, 0);
      psel1 = 1'b0; penable = 1'b0;
      model_reset();
      @(posedge pclk); #1;
      presetn = 1'b1;
      @(posedge pclk); #1;
      xfer(1, 0, 8'h06, 8'h00);
      xfer(1, 0, 8'h05, 8'h00);
      idle(1);
      check_status(1);

      // error counter saturation
      for (int k = 0; k < 258; k++) xfer(2, 0, 8'h50, 8'h00);
      idle(1);
      check_status(2);

      // abort mid-ACCESS
      xfer(1, 1, 8'h07, 8'h3C);
      idle(1);
      psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h007; pwdata = 8'hC3;
      @(posedge pclk); #1 penable = 1'b1;
      @(posedge pclk); #1 psel1 = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      xfer(1, 0, 8'h07, 8'h00);
      idle(1);
      check_status(1);

      // randomized traffic against the model
      for (int k = 0; k < 300; k++) begin
         r = $urandom_range(0, 9);
         if (r < 7)       a = 8'($urandom_range(0, 63));
         else if (r == 7) a = 8'hFF;
         else if (r == 8) a = 8'($urandom_range(64, 254));
         else             a = 8'($urandom_range(0, 255));
         xfer($urandom_range(1, 2), 1'($urandom_range(0, 1)), a, 8'($urandom));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(3);
      check_status(1);
      check_status(2);
      check("scoreboard_drained", q1.size() + q2.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
